// File: rtl/t05_huff_decoder.sv
// ---------------------------------------------------------------------------
// t05_huff_decoder
//
// Rebuilds characters from a Huffman bitstream by walking the stored htree
// one code bit at a time, from the root node down to a leaf. Each decoded
// 8-bit character is presented on a valid/ready port. The root node is
// fetched again for every symbol.
//
// The block sits between the SRAM htree store and the writer for the
// decompressed output.
//
// Optional feature (compile-time macro HUFF_DEC_COUNT_EN):
//   When defined, the block adds the output char_count[15:0]. It counts
//   character handshakes, saturates at 16'hFFFF and is cleared by rst or by
//   an accepted start.
//   When undefined, neither the port nor the counter exists.
//
// Ports
//   clk         in   1       system clock
//   rst         in   1       synchronous, active-high reset
//   start       in   1       begin decoding; accepted only in IDLE/DONE/ERROR
//   root_index  in   IDX_W   root node index, sampled on an accepted start
//   node_req    out  1       tree read request, held until node_ack
//   node_idx    out  IDX_W   requested tree index, stable while node_req=1
//   node_ack    in   1       node_data is valid in this cycle
//   node_data   in   NODE_W  htree element {max_index, left, right, sum}
//   bit_valid   in   1       a code bit is present
//   bit_in      in   1       code bit: 0 = left child, 1 = right child
//   bit_last    in   1       marks bit_in as the final bit of the stream
//   bit_ready   out  1       a bit is consumed when bit_valid & bit_ready
//   char_valid  out  1       a decoded character is available
//   char_out    out  8       the decoded character
//   char_ready  in   1       downstream accepts the character
//   done        out  1       stream fully decoded; held until start/rst
//   err         out  1       sticky decode error; cleared by start/rst
//   char_count  out  16      handshake count (only with HUFF_DEC_COUNT_EN)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module t05_huff_decoder #(
    parameter int NODE_W    = 71,
    parameter int IDX_W     = 7,
    parameter int MAX_DEPTH = 127
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  root_index,
    output logic              node_req,
    output logic [IDX_W-1:0]  node_idx,
    input  logic              node_ack,
    input  logic [NODE_W-1:0] node_data,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              bit_last,
    output logic              bit_ready,
    output logic              char_valid,
    output logic [7:0]        char_out,
    input  logic              char_ready,
    output logic              done,
    output logic              err
`ifdef HUFF_DEC_COUNT_EN
    ,
    output logic [15:0]       char_count
`endif
);

    // Field positions inside one htree element:
    // {max_index[IDX_W-1:0], left[8:0], right[8:0], sum[...]}
    localparam int L_HI = NODE_W - IDX_W - 1;
    localparam int R_HI = L_HI - 9;

    localparam logic [8:0] NULL_CHILD = 9'h180;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_BIT   = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_root;
    logic [IDX_W-1:0] r_cur;
    logic [IDX_W-1:0] r_depth;
    logic             r_last;
    logic [8:0]       r_left;
    logic [8:0]       r_right;
    logic             r_single;
    logic [7:0]       r_char;

    logic [8:0]       w_child;
    logic             w_is_leaf;
    logic             w_bad;
    logic             w_start_ok;
    logic             w_unused;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // max_index and sum are not needed to walk the tree.
    assign w_unused = ^{node_data[NODE_W-1:L_HI+1], node_data[R_HI-9:0]};

    // A single-symbol tree has a null right child at the root. In that case
    // every bit, whatever its value, selects the left leaf, so each symbol
    // still costs exactly one bit.
    assign w_child   = (r_single || !bit_in) ? r_left : r_right;
    assign w_is_leaf = !w_child[8];

    // The following conditions are errors on an internal child:
    //   - a null child;
    //   - a malformed index (bit 7 set);
    //   - the stream ending partway through a code;
    //   - a code growing past MAX_DEPTH bits.
    assign w_bad = (w_child == NULL_CHILD) || w_child[7] || bit_last ||
                   (r_depth == IDX_W'(MAX_DEPTH - 1));

    assign w_start_ok = start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) ||
                         (r_state == S_ERROR));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs decode only the registered state and registers, so there is no
    // combinational path from any input to bit_ready or char_valid.
    always_comb begin
        w_state_next = r_state;
        node_req     = 1'b0;
        bit_ready    = 1'b0;
        char_valid   = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        node_idx     = r_cur;
        char_out     = r_char;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                node_req = 1'b1;
                if (node_ack) w_state_next = S_BIT;
            end
            S_BIT: begin
                bit_ready = 1'b1;
                if (bit_valid) begin
                    if (w_is_leaf)  w_state_next = S_EMIT;
                    else if (w_bad) w_state_next = S_ERROR;
                    else            w_state_next = S_FETCH;
                end
            end
            S_EMIT: begin
                char_valid = 1'b1;
                if (char_ready) w_state_next = r_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_next = S_FETCH;
            end
            S_ERROR: begin
                err = 1'b1;
                if (start) w_state_next = S_FETCH;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_root   <= '0;
            r_cur    <= '0;
            r_depth  <= '0;
            r_last   <= 1'b0;
            r_left   <= '0;
            r_right  <= '0;
            r_single <= 1'b0;
            r_char   <= '0;
        end else begin
            if (w_start_ok) begin
                r_root  <= root_index;
                r_cur   <= root_index;
                r_depth <= '0;
                r_last  <= 1'b0;
            end
            if ((r_state == S_FETCH) && node_ack) begin
                r_left   <= node_data[L_HI -: 9];
                r_right  <= node_data[R_HI -: 9];
                r_single <= (r_depth == '0) &&
                            (node_data[R_HI -: 9] == NULL_CHILD);
            end
            if ((r_state == S_BIT) && bit_valid) begin
                r_depth <= r_depth + IDX_W'(1);
                r_last  <= bit_last;
                if (w_is_leaf) r_char <= w_child[7:0];
                else           r_cur  <= w_child[IDX_W-1:0];
            end
            if ((r_state == S_EMIT) && char_ready && !r_last) begin
                r_cur   <= r_root;
                r_depth <= '0;
            end
        end
    end

`ifdef HUFF_DEC_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_count <= '0;
        end else if ((r_state == S_EMIT) && char_ready) begin
            r_count <= sat_inc16(r_count);
        end
    end

    assign char_count = r_count;
`endif

endmodule

// File: tb/tb_t05_huff_decoder.sv
`timescale 1ns/1ps

module tb_t05_huff_decoder;
    localparam int NODE_W = 71;
    localparam int IDX_W  = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IDX_W-1:0]  root_index;
    logic              node_req;
    logic [IDX_W-1:0]  node_idx;
    logic              node_ack;
    logic [NODE_W-1:0] node_data;
    logic              bit_valid;
    logic              bit_in;
    logic              bit_last;
    logic              bit_ready;
    logic              char_valid;
    logic [7:0]        char_out;
    logic              char_ready;
    logic              done;
    logic              err;
`ifdef HUFF_DEC_COUNT_EN
    logic [15:0]       char_count;
`endif

    always #5 clk = ~clk;

    t05_huff_decoder dut (
        .clk(clk), .rst(rst), .start(start), .root_index(root_index),
        .node_req(node_req), .node_idx(node_idx), .node_ack(node_ack),
        .node_data(node_data), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_last(bit_last), .bit_ready(bit_ready), .char_valid(char_valid),
        .char_out(char_out), .char_ready(char_ready), .done(done), .err(err)
`ifdef HUFF_DEC_COUNT_EN
        , .char_count(char_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    logic [NODE_W-1:0] mem [0:127];
    logic [7:0]        exp_q [$];
    int                fetch_q [$];
    logic [3:0]        code_val [10];
    int                code_len [10];
    bit                rdy_force_en = 1'b1;
    bit                rdy_force_val = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] leaf(input int c);
        return {1'b0, 8'(c)};
    endfunction

    function automatic logic [8:0] inode(input int i);
        return {2'b10, 7'(i)};
    endfunction

    function automatic logic [NODE_W-1:0] mk(input logic [8:0] l, input logic [8:0] r);
        logic [63:0] s;
        s = {$urandom, $urandom};
        return {7'($urandom), l, r, s[45:0]};
    endfunction

    // Test tree rooted at 8, plus a single-symbol tree rooted at 9.
    // Code table derived by hand from that tree (0 = left), first bit is MSB.
    task automatic build_tree();
        for (int i = 0; i < 128; i++) mem[i] = mk(9'h180, 9'h180);
        mem[0] = mk(leaf(67), leaf(66));
        mem[1] = mk(leaf(68), leaf(69));
        mem[2] = mk(leaf(72), leaf(73));
        mem[3] = mk(inode(0), leaf(65));
        mem[4] = mk(leaf(70), inode(1));
        mem[5] = mk(leaf(71), inode(2));
        mem[6] = mk(inode(3), inode(4));
        mem[7] = mk(leaf(74), inode(5));
        mem[8] = mk(inode(6), inode(7));
        mem[9] = mk(leaf(67), 9'h180);
        // A=001 B=0001 C=0000 D=0110 E=0111 F=010 G=110 H=1110 I=1111 J=10
        code_val[0] = 4'b0001; code_len[0] = 3;
        code_val[1] = 4'b0001; code_len[1] = 4;
        code_val[2] = 4'b0000; code_len[2] = 4;
        code_val[3] = 4'b0110; code_len[3] = 4;
        code_val[4] = 4'b0111; code_len[4] = 4;
        code_val[5] = 4'b0010; code_len[5] = 3;
        code_val[6] = 4'b0110; code_len[6] = 3;
        code_val[7] = 4'b1110; code_len[7] = 4;
        code_val[8] = 4'b1111; code_len[8] = 4;
        code_val[9] = 4'b0010; code_len[9] = 2;
    endtask

    // SRAM model: acknowledges each request after a random delay of 1..3 cycles.
    initial begin
        logic [IDX_W-1:0] idx;
        int lat;
        node_ack  = 1'b0;
        node_data = '0;
        forever begin
            @(negedge clk);
            if (node_req && !rst) begin
                idx = node_idx;
                lat = $urandom_range(0, 2);
                repeat (lat) begin
                    @(negedge clk);
                    if (node_req) check("node_idx_stable", node_idx, idx);
                end
                @(posedge clk); #1;
                node_ack  = 1'b1;
                node_data = mem[idx];
                fetch_q.push_back(int'(idx));
                @(posedge clk); #1;
                node_ack  = 1'b0;
                node_data = mk(9'h1FF, 9'h1FF);
            end
        end
    end

    // Downstream ready: either forced or random.
    initial begin
        char_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            char_ready = rdy_force_en ? rdy_force_val : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on each character handshake.
    initial begin
        bit         held;
        logic [7:0] held_val;
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (bit_ready || char_valid) check("ready_valid_exclusive", bit_ready & char_valid, 0);
            if (!rst && char_valid) begin
                if (held) check("char_hold", char_out, held_val);
                if (char_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_char: got %0d required none", char_out);
                    end else begin
                        check("char_out", char_out, exp_q.pop_front());
                    end
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_val = char_out;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int root);
        @(posedge clk); #1;
        start = 1'b1;
        root_index = 7'(root);
        tick();
        start = 1'b0;
        root_index = 7'($urandom);
        check("start_req", node_req, 1);
        check("start_done_clr", done, 0);
        check("start_err_clr", err, 0);
    endtask

    task automatic send_bit(input logic b, input logic l);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        bit_valid = 1'b1;
        bit_in = b;
        bit_last = l;
        while (n < 200) begin
            @(negedge clk);
            if (bit_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL bit_timeout: got no bit_ready required bit_ready within 200 cycles");
        end
        tick();
        bit_valid = 1'b0;
        bit_in = 1'($urandom);
        bit_last = 1'($urandom);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic send_syms(input int syms[$]);
        int len;
        foreach (syms[i]) exp_q.push_back(8'(65 + syms[i]));
        foreach (syms[i]) begin
            len = code_len[syms[i]];
            for (int b = len - 1; b >= 0; b--)
                send_bit(code_val[syms[i]][b], (i == syms.size() - 1) && (b == 0));
        end
    endtask

    task automatic wait_end(input string name, input logic exp_done, input logic exp_err);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (done || err) break;
            n++;
        end
        repeat (2) @(negedge clk);
        check({name, "_done"}, done, exp_done);
        check({name, "_err"}, err, exp_err);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int syms[$];
        int n;
        int exp_f[5];
        rst = 1'b1;
        start = 1'b0;
        root_index = '0;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        bit_last = 1'b0;
        build_tree();
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_node_req", node_req, 0);
        check("rst_bit_ready", bit_ready, 0);
        check("rst_char_valid", char_valid, 0);
        check("rst_char_out", char_out, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // 1: 0000 -> 'C'
        rdy_force_en = 1'b1; rdy_force_val = 1'b1;
        exp_q.push_back(8'd67);
        do_start(8);
        send_bit(0, 0); send_bit(0, 0); send_bit(0, 0); send_bit(0, 1);
        wait_end("t1", 1, 0);
`ifdef HUFF_DEC_COUNT_EN
        check("t1_count", char_count, 1);
`endif

        // 2: 10 | 001 -> 'J','A', fetches 8,7,8,6,3
        rdy_force_en = 1'b0;
        exp_q.push_back(8'd74); exp_q.push_back(8'd65);
        fetch_q.delete();
        do_start(8);
        send_bit(1, 0); send_bit(0, 0); send_bit(0, 0); send_bit(0, 0); send_bit(1, 1);
        wait_end("t2", 1, 0);
        exp_f = '{8, 7, 8, 6, 3};
        check("t2_fetch_count", fetch_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < fetch_q.size()) check("t2_fetch_idx", fetch_q[i], exp_f[i]);

        // 3: single-symbol tree, any bit decodes to 'C'
        repeat (3) exp_q.push_back(8'd67);
        do_start(9);
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 1);
        wait_end("t3", 1, 0);

        // 4: stream ends on an internal node -> err
        do_start(8);
        send_bit(0, 0); send_bit(0, 1);
        wait_end("t4", 0, 1);

        // start while busy is ignored: 1,(start to 9),0 -> 'J'
        exp_q.push_back(8'd74);
        do_start(8);
        send_bit(1, 0);
        start = 1'b1; root_index = 7'd9;
        tick();
        start = 1'b0;
        send_bit(0, 1);
        wait_end("busy_start", 1, 0);

        // 5: hold char_ready low for 5 cycles on 'J'
        rdy_force_en = 1'b1; rdy_force_val = 1'b0;
        exp_q.push_back(8'd74);
        do_start(8);
        send_bit(1, 0); send_bit(0, 1);
        n = 0;
        while (!char_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_valid_held", char_valid, 1);
            check("t5_char_held", char_out, 74);
            check("t5_bit_ready_low", bit_ready, 0);
        end
        rdy_force_val = 1'b1;
        wait_end("t5", 1, 0);

        // 6: reset during FETCH of node 6, then a clean decode
        do_start(8);
        send_bit(0, 0);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (node_req && node_idx == 7'd6) break;
            n++;
        end
        check("t6_fetch6_seen", node_idx, 6);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_node_req", node_req, 0);
        check("t6_bit_ready", bit_ready, 0);
        check("t6_char_valid", char_valid, 0);
        check("t6_char_out", char_out, 0);
        check("t6_done", done, 0);
        check("t6_err", err, 0);
        rst = 1'b0;
        repeat (6) tick();
        check("t6_idle", node_req, 0);
        exp_q.push_back(8'd67);
        do_start(8);
        send_bit(0, 0); send_bit(0, 0); send_bit(0, 0); send_bit(0, 1);
        wait_end("t6", 1, 0);
`ifdef HUFF_DEC_COUNT_EN
        check("t6_count", char_count, 1);
`endif

        // Random symbol streams encoded with the code table
        rdy_force_en = 1'b0;
        for (int r = 0; r < 20; r++) begin
            syms.delete();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) syms.push_back($urandom_range(0, 9));
            do_start(8);
            send_syms(syms);
            wait_end("rand", 1, 0);
`ifdef HUFF_DEC_COUNT_EN
            check("rand_count", char_count, n);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
